// File: rtl/btn_evt_pkg.sv
// Shared types for the button event arbiter: per-button FSM states,
// event type encodings and the event record carried through the FIFO.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

    // Record id field is sized for up to 256 buttons; the top truncates to ID_W.
    localparam int unsigned EVT_ID_W = 8;

    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic                is_long;
    } evt_rec_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry one extra bit
// so full and empty are distinguishable. Push is refused while full.
module btn_evt_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         push_ok;
    logic         pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign wr_ptr_d  = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d  = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; readers qualify the head with !empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Classifies debounced button presses as short/long, arbitrates them round-robin
// into an event FIFO. Define BTN_REPEAT_EN to add auto-repeat long events while held.
module btn_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned LONG_TICKS   = 25000000,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned REPEAT_TICKS = 5000000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_BTN-1:0]                      btn_level,
    input  logic [N_BTN-1:0]                      btn_pulse,
    output logic                                  evt_valid,
    input  logic                                  evt_ready,
    output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] evt_id,
    output logic                                  evt_long,
    output logic                                  evt_overflow,
    output logic                                  busy
);

    localparam int unsigned ID_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int unsigned CNT_W = $clog2(max_u(LONG_TICKS, REPEAT_TICKS) + 1);
    localparam int unsigned REC_W = $bits(evt_rec_t);

    logic [N_BTN-1:0] ev_set_c;
    logic [N_BTN-1:0] ev_long_c;
    logic [N_BTN-1:0] st_busy_c;

    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] type_q, type_d;
    logic             ovf_q, ovf_d;
    logic [ID_W-1:0]  rr_q, rr_d;

    logic             gnt_vld_c;
    logic [ID_W-1:0]  gnt_idx_c;
    logic [ID_W-1:0]  idx_v;
    logic [N_BTN-1:0] gnt_oh_c;
    logic [N_BTN-1:0] drop_c;
    logic [N_BTN-1:0] accept_c;
    logic             push_c;
    logic             pop_c;

    logic             fifo_full;
    logic             fifo_empty;
    evt_rec_t         push_rec;
    evt_rec_t         head_rec;
    logic [REC_W-1:0] fifo_rd_data;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        return (idx == ID_W'(N_BTN - 1)) ? '0 : idx + ID_W'(1);
    endfunction

    // Per-button press classifier
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             ev_set;
        logic             ev_long;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ev_set  = 1'b0;
            ev_long = EVT_SHORT;
            unique case (state_q)
                ST_IDLE: begin
                    if (btn_pulse[g]) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_level[g]) begin
                        ev_set  = 1'b1;
                        ev_long = EVT_SHORT;
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_W'(LONG_TICKS - 1)) begin
                        ev_set  = 1'b1;
                        ev_long = EVT_LONG;
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!btn_level[g]) begin
                        state_d = ST_IDLE;
                    end
`ifdef BTN_REPEAT_EN
                    else if (cnt_q == CNT_W'(REPEAT_TICKS - 1)) begin
                        ev_set  = 1'b1;
                        ev_long = EVT_LONG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign ev_set_c[g]  = ev_set;
        assign ev_long_c[g] = ev_long;
        assign st_busy_c[g] = (state_q != ST_IDLE);
    end

    // Round-robin search starting at rr_q, wrapping at N_BTN
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        idx_v     = rr_q;
        for (int unsigned off = 0; off < N_BTN; off++) begin
            if (!gnt_vld_c && pend_q[idx_v]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = idx_v;
            end
            idx_v = next_idx(idx_v);
        end
    end

    assign push_c   = gnt_vld_c && !fifo_full;
    assign pop_c    = evt_valid && evt_ready;
    assign gnt_oh_c = push_c ? (N_BTN'(1) << gnt_idx_c) : '0;

    // A slot being granted this cycle is free to accept a new event.
    always_comb begin
        drop_c   = ev_set_c & pend_q & ~gnt_oh_c;
        accept_c = ev_set_c & ~drop_c;
        pend_d   = (pend_q & ~gnt_oh_c) | accept_c;
        type_d   = (type_q & ~accept_c) | (ev_long_c & accept_c);
        ovf_d    = ovf_q | (|drop_c);
        rr_d     = push_c ? next_idx(gnt_idx_c) : rr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            type_q <= '0;
            ovf_q  <= 1'b0;
            rr_q   <= '0;
        end else begin
            pend_q <= pend_d;
            type_q <= type_d;
            ovf_q  <= ovf_d;
            rr_q   <= rr_d;
        end
    end

    always_comb begin
        push_rec         = '0;
        push_rec.id      = EVT_ID_W'(gnt_idx_c);
        push_rec.is_long = type_q[gnt_idx_c];
    end

    btn_evt_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_c),
        .wr_data_i (push_rec),
        .pop_i     (pop_c),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign head_rec     = evt_rec_t'(fifo_rd_data);
    assign evt_valid    = !fifo_empty;
    assign evt_id       = evt_valid ? ID_W'(head_rec.id) : '0;
    assign evt_long     = evt_valid & head_rec.is_long;
    assign evt_overflow = ovf_q;
    assign busy         = (|st_busy_c) | (|pend_q);

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with LONG_TICKS=8, FIFO_DEPTH=2, REPEAT_TICKS=4.
module tb_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_long;
    logic       evt_overflow;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    btn_event_arbiter #(
        .N_BTN        (4),
        .LONG_TICKS   (8),
        .FIFO_DEPTH   (2),
        .REPEAT_TICKS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_level    (lvl),
        .btn_pulse    (pls),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .evt_long     (evt_long),
        .evt_overflow (evt_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [1:0] id, input logic lg);
        chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
        chk({tag, ".id"},    32'(evt_id),    32'(id));
        chk({tag, ".long"},  32'(evt_long),  32'(lg));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Short press on every button in mask; returns right after the edge that sets pending.
    task automatic short_evt(input logic [3:0] mask);
        lvl = lvl | mask;
        pls = mask;
        tick();
        pls = '0;
        tick();
        lvl = lvl & ~mask;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        lvl       = '0;
        pls       = '0;
        evt_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk_head("rst", 1'b0, 2'd0, 1'b0);
        chk("rst.ovf",  32'(evt_overflow), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Button 1 short press: level high for 3 cycles
        lvl[1] = 1'b1;
        pls[1] = 1'b1;
        tick();
        pls[1] = 1'b0;
        chk("short.busy_pressed", 32'(busy), 32'd1);
        tick();
        tick();
        lvl[1] = 1'b0;
        tick();
        chk("short.not_yet", 32'(evt_valid), 32'd0);
        chk("short.busy_pend", 32'(busy), 32'd1);
        tick();
        chk_head("short.evt", 1'b1, 2'd1, 1'b0);
        chk("short.busy_idle", 32'(busy), 32'd0);
        tick();
        chk("short.popped", 32'(evt_valid), 32'd0);

        // Button 2 long press: event after 8 cycles held
        lvl[2] = 1'b1;
        pls[2] = 1'b1;
        tick();
        pls[2] = 1'b0;
        for (int t = 1; t <= 8; t++) tick();
        chk("long.not_yet", 32'(evt_valid), 32'd0);
        tick();
        chk_head("long.evt", 1'b1, 2'd2, 1'b1);
        tick();
        chk("long.popped", 32'(evt_valid), 32'd0);
        chk("long.busy_held", 32'(busy), 32'd1);
`ifndef BTN_REPEAT_EN
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("long.held_silent", 32'(evt_valid), 32'd0);
        end
`endif
        lvl[2] = 1'b0;
        tick();
        tick();
        chk("long.release_silent", 32'(evt_valid), 32'd0);
        chk("long.busy_release", 32'(busy), 32'd0);

        // Round-robin ties from rr_ptr=0
        do_reset();
        short_evt(4'b1001);
        chk("rr03.pending", 32'(evt_valid), 32'd0);
        tick();
        chk_head("rr03.first", 1'b1, 2'd0, 1'b0);
        tick();
        chk_head("rr03.second", 1'b1, 2'd3, 1'b0);
        tick();
        chk("rr03.empty", 32'(evt_valid), 32'd0);
        short_evt(4'b1010);
        tick();
        chk_head("rr13.first", 1'b1, 2'd1, 1'b0);
        tick();
        chk_head("rr13.second", 1'b1, 2'd3, 1'b0);
        tick();
        // Single grant to 2 moves the pointer to 3, so 3 beats 0 next
        short_evt(4'b0100);
        tick();
        chk_head("rr2.only", 1'b1, 2'd2, 1'b0);
        tick();
        short_evt(4'b1001);
        tick();
        chk_head("rr30.first", 1'b1, 2'd3, 1'b0);
        tick();
        chk_head("rr30.second", 1'b1, 2'd0, 1'b0);
        tick();
        chk("rr30.empty", 32'(evt_valid), 32'd0);

        // Back-pressure: pointer now 1, three events with FIFO of 2
        evt_ready = 1'b0;
        short_evt(4'b0111);
        tick();
        tick();
        tick();
        chk_head("bp.head_stable", 1'b1, 2'd1, 1'b0);
        chk("bp.busy_pend", 32'(busy), 32'd1);
        chk("bp.ovf", 32'(evt_overflow), 32'd0);
        evt_ready = 1'b1;
        tick();
        chk_head("bp.drain2", 1'b1, 2'd2, 1'b0);
        chk("bp.push_blocked_full", 32'(busy), 32'd1);
        tick();
        chk_head("bp.drain3", 1'b1, 2'd0, 1'b0);
        tick();
        chk("bp.empty", 32'(evt_valid), 32'd0);
        chk("bp.busy_done", 32'(busy), 32'd0);

        // Overflow: FIFO full, two short presses on button 0
        evt_ready = 1'b0;
        short_evt(4'b0110);
        tick();
        tick();
        short_evt(4'b0001);
        chk("ovf.first_kept", 32'(evt_overflow), 32'd0);
        short_evt(4'b0001);
        chk("ovf.set", 32'(evt_overflow), 32'd1);
        chk_head("ovf.head", 1'b1, 2'd1, 1'b0);
        evt_ready = 1'b1;
        tick();
        chk_head("ovf.drain2", 1'b1, 2'd2, 1'b0);
        tick();
        chk_head("ovf.drain3", 1'b1, 2'd0, 1'b0);
        tick();
        chk("ovf.empty", 32'(evt_valid), 32'd0);
        tick();
        tick();
        chk("ovf.no_fourth", 32'(evt_valid), 32'd0);
        chk("ovf.sticky", 32'(evt_overflow), 32'd1);

        // Reset in the middle of a press on button 1
        lvl[1] = 1'b1;
        pls[1] = 1'b1;
        tick();
        pls[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_head("midrst", 1'b0, 2'd0, 1'b0);
        chk("midrst.ovf",  32'(evt_overflow), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            chk("midrst.held_no_evt", 32'(evt_valid), 32'd0);
        end
        lvl[1] = 1'b0;
        tick();
        tick();
        chk("midrst.release", 32'(evt_valid), 32'd0);
        chk("midrst.busy_end", 32'(busy), 32'd0);

`ifdef BTN_REPEAT_EN
        // Auto-repeat: 20-cycle hold on button 0
        do_reset();
        lvl[0] = 1'b1;
        pls[0] = 1'b1;
        tick();
        pls[0] = 1'b0;
        for (int t = 1; t <= 22; t++) begin
            logic e;
            tick();
            e = (t == 9) || (t == 13) || (t == 17) || (t == 21);
            chk("rep.valid", 32'(evt_valid), 32'(e));
            chk("rep.long",  32'(evt_long),  32'(e));
            if (t == 20) lvl[0] = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Consumes the level and rising-edge pulse outputs of N_BTN per-button debouncers.
- Classifies each press as short or long, and arbitrates simultaneous events round-robin.
- Buffers events in a small FIFO and presents them one at a time on a valid/ready interface.
- Sits between the debouncer bank and the UI/menu control FSM.

Parameters:
- N_BTN, 4: number of debounced buttons served.
- LONG_TICKS, 25000000: cycles the level must stay high after the pulse to count as a long press (0.5 s @50 MHz). Must be ≥2.
- FIFO_DEPTH, 4: event FIFO entries. Power of two, ≥2.
- REPEAT_TICKS, 5000000: auto-repeat period in cycles. Used only when BTN_REPEAT_EN is defined.
- Derived localparams: ID_W = max(1, clog2(N_BTN)); CNT_W = clog2(max(LONG_TICKS, REPEAT_TICKS)+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- btn_level  in  N_BTN  debounced button levels.
- btn_pulse  in  N_BTN  single-cycle rising-edge pulses from the debouncers.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_id  out  ID_W  button index of the head event.
- evt_long  out  1  head event type: 0 = short, 1 = long.
- evt_overflow  out  1  sticky: an event was dropped. Cleared only by rst.
- busy  out  1  any button FSM not in IDLE, or any pending flag set.

Behaviour:
- Reset (rst high at a clk edge): all button FSMs go to IDLE. Counters = 0, pending flags = 0, round-robin pointer = 0, FIFO empty. evt_valid=0, evt_id=0, evt_long=0, evt_overflow=0, busy=0. Reset mid-press discards the press: a button still held after reset produces no event until its next btn_pulse.
- Per-button FSM (one instance per button, one shared CNT_W counter each):
  - IDLE: btn_pulse[i]=1 → PRESSED, cnt=0.
  - PRESSED:
    - btn_level[i]=0 → set pending SHORT, go to IDLE.
    - Otherwise, if cnt == LONG_TICKS-1 → set pending LONG, go to HELD.
    - Otherwise cnt++.
  - HELD: btn_level[i]=0 → IDLE, no event.
  - btn_pulse[i] outside IDLE is ignored.
- Pending slot per button: one flag plus one type bit.
  - If a new event arrives while the slot is still set, the new event is dropped and evt_overflow is set. The older event is kept.
- Arbiter: each cycle, if the FIFO is not full and any pending flag is set, grant the first set flag searching from rr_ptr upward with wrap.
  - Push {i, type} into the FIFO and clear pending[i].
  - rr_ptr ← (i+1) mod N_BTN.
  - At most one push per cycle.
- FIFO:
  - Push is blocked when full, even if a pop happens in the same cycle. The pending slot holds the event meanwhile (back-pressure, no drop).
  - Pop occurs when evt_valid && evt_ready.
  - A simultaneous push and pop when not full keeps the count unchanged.
  - Outputs: evt_valid = !empty; evt_id/evt_long = head entry, stable while evt_valid && !evt_ready.
- Latency: the FSM transition at edge k sets pending at k; the push happens at k+1; evt_valid is high after k+1 when the FIFO was empty.
- Pointers wrap modulo FIFO_DEPTH, with one extra bit for full/empty disambiguation.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - Entering HELD clears cnt.
  - In HELD, each time cnt reaches REPEAT_TICKS-1 while the level is high, set pending LONG and reset cnt to 0. The normal slot-collision rule applies.
  - A release still produces no event.
- Undefined: HELD is silent, REPEAT_TICKS is unused, and no repeat logic is synthesised.

Decomposition:
- Package btn_evt_pkg:
  - Per-button state enum {ST_IDLE, ST_PRESSED, ST_HELD}.
  - Event type constants EVT_SHORT=0, EVT_LONG=1.
  - Event record type {id, long}.
- Sub-module btn_evt_fifo: synchronous FIFO parameterised on width and depth, with full/empty flags. This is the natural single split.
- The per-button FSMs are a generate loop in the top level.

Test Plan (LONG_TICKS=8, FIFO_DEPTH=2, REPEAT_TICKS=4, evt_ready=1 unless stated):
- Button 1 pulse, level high 3 cycles then low → exactly one event id=1, long=0. evt_valid rises 2 cycles after the level drops.
- Button 2 pulse, level held 20 cycles → one event id=2, long=1 after 8 cycles held. Nothing on release.
- Buttons 0 and 3 release short presses in the same cycle with rr_ptr=0 → events id=0 then id=3 on consecutive cycles. The next tie favours id=1.
- evt_ready=0; three buttons produce short events → FIFO holds 2, the third stays pending, evt_overflow=0. Raising evt_ready drains all 3 in grant order.
- evt_ready=0, FIFO full; button 0 produces two short presses → the second is dropped and evt_overflow=1, sticky until rst.
- Assert rst mid-PRESSED on button 1 → all outputs 0 the next cycle; a continued hold yields no event. With BTN_REPEAT_EN defined, a 20-cycle hold on button 0 yields long events at hold cycles 8, 12, 16 and 20.
